// File: rtl/drp_rmw_master.sv
// ---------------------------------------------------------------------------
// drp_rmw_master
//
// DRP initiator for GTPE2_COMMON / GTPE2_CHANNEL ports. Accepts single reads
// and masked read-modify-write requests on a valid/ready interface and turns
// them into DRP_EN / DRP_WE / DRP_RDY sequences. Everything runs on drp_clk.
//
// Handshake: a request transfers on a drp_clk edge where req_valid and
// req_ready are both high; req_ready is high only while idle. Responses are a
// single-cycle rsp_valid pulse with no backpressure; rsp_timeout and rsp_data
// are meaningful only while rsp_valid is high.
//
// Ports
//   drp_clk, rst         clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake
//   req_we               0 = read, 1 = masked write
//   req_addr             DRP address
//   req_mask, req_data   bits to replace / their new values (writes only)
//   rsp_valid            one-cycle response pulse
//   rsp_data             read word, final written word, or 0 on timeout
//   rsp_timeout          transaction aborted waiting for drp_rdy
//   drp_addr/en/we/di    to the DRP port
//   drp_do, drp_rdy      from the DRP port
//   state_dbg            current FSM state for observation
// ---------------------------------------------------------------------------
module drp_rmw_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        drp_clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_mask,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic [7:0]  drp_addr,
  output logic        drp_en,
  output logic        drp_we,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_rdy,
  output logic [2:0]  state_dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Counter value seen in the last permitted wait cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_EN   = 3'd1,
    RD_WAIT = 3'd2,
    WR_EN   = 3'd3,
    WR_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          we_q;
  logic [15:0]   mask_q, data_q;
  logic [15:0]   merged_q, merged_next;
  logic [15:0]   rsp_data_next;
  logic          rsp_timeout_next;
  logic          accept;

  assign state_dbg = state;
  // req_ready is registered, so it also covers the first cycle after reset.
  assign accept    = (state == IDLE) && req_ready && req_valid;

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    merged_next      = merged_q;
    rsp_data_next    = rsp_data;
    rsp_timeout_next = rsp_timeout;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_we && (req_mask == 16'hFFFF)) begin
            // Every bit is replaced, so the old contents are irrelevant.
            merged_next = req_data;
            state_next  = WR_EN;
          end else begin
            state_next  = RD_EN;
          end
        end
      end
      RD_EN: begin
        cnt_next   = '0;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (drp_rdy) begin
          rsp_timeout_next = 1'b0;
          if (!we_q) begin
            rsp_data_next = drp_do;
            state_next    = RESP;
          end else begin
            merged_next = (drp_do & ~mask_q) | (data_q & mask_q);
            if (mask_q == 16'h0000) begin
              // Empty mask: nothing changes, report the word as read.
              rsp_data_next = drp_do;
              state_next    = RESP;
            end else begin
              state_next = WR_EN;
            end
          end
        end else if (cnt == CNT_LAST) begin
          rsp_data_next    = 16'h0000;
          rsp_timeout_next = 1'b1;
          state_next       = RESP;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      WR_EN: begin
        cnt_next   = '0;
        state_next = WR_WAIT;
      end
      WR_WAIT: begin
        if (drp_rdy) begin
          rsp_data_next    = merged_q;
          rsp_timeout_next = 1'b0;
          state_next       = RESP;
        end else if (cnt == CNT_LAST) begin
          rsp_data_next    = 16'h0000;
          rsp_timeout_next = 1'b1;
          state_next       = RESP;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they belong to without a cycle of lag.
  always_ff @(posedge drp_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      mask_q      <= 16'h0000;
      data_q      <= 16'h0000;
      merged_q    <= 16'h0000;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 16'h0000;
      rsp_timeout <= 1'b0;
      drp_addr    <= 8'h00;
      drp_en      <= 1'b0;
      drp_we      <= 1'b0;
      drp_di      <= 16'h0000;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      merged_q <= merged_next;
      if (accept) begin
        we_q     <= req_we;
        mask_q   <= req_mask;
        data_q   <= req_data;
        drp_addr <= req_addr;
      end
      req_ready   <= (state_next == IDLE);
      rsp_valid   <= (state_next == RESP);
      rsp_data    <= rsp_data_next;
      rsp_timeout <= rsp_timeout_next;
      drp_en      <= (state_next == RD_EN) || (state_next == WR_EN);
      drp_we      <= (state_next == WR_EN);
      drp_di      <= (state_next == WR_EN) ? merged_next : 16'h0000;
    end
  end

endmodule

// File: tb/tb_drp_rmw_master.sv
// ---------------------------------------------------------------------------
// tb_drp_rmw_master
//
// Drives drp_rmw_master against a behavioural DRP device (register file with
// programmable ready latency) and compares every response with a reference
// model that works from request semantics: expected word, expected number of
// DRP enables / writes, and expected response cycle derived from latencies.
// ---------------------------------------------------------------------------
module tb_drp_rmw_master;

  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] req_mask = 16'h0000;
  logic [15:0] req_data = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic [7:0]  drp_addr;
  logic        drp_en;
  logic        drp_we;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'h0000;
  logic        drp_rdy = 1'b0;
  logic [2:0]  state_dbg;

  drp_rmw_master #(.TIMEOUT(TMO)) dut (
    .drp_clk     (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_mask    (req_mask),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .drp_addr    (drp_addr),
    .drp_en      (drp_en),
    .drp_we      (drp_we),
    .drp_di      (drp_di),
    .drp_do      (drp_do),
    .drp_rdy     (drp_rdy),
    .state_dbg   (state_dbg)
  );

  // ---------------- DRP device model ----------------
  // Latency 0 means the device never answers.
  logic [15:0] dev_mem [256];
  int          rd_lat = 1;
  int          wr_lat = 1;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_do = 16'h0000;
  bit          stray = 1'b0;
  int          en_cnt = 0;
  int          we_cnt = 0;
  logic [15:0] last_di = 16'h0000;

  always @(negedge clk) begin
    drp_rdy = 1'b0;
    if (stray) begin
      drp_rdy = 1'b1;
      drp_do  = 16'($urandom);
      stray   = 1'b0;
    end
    if (pend) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        drp_rdy = 1'b1;
        drp_do  = pend_do;
        pend    = 1'b0;
      end
    end
    if (drp_en && !rst) begin
      en_cnt = en_cnt + 1;
      if (drp_we) begin
        we_cnt = we_cnt + 1;
        last_di = drp_di;
        dev_mem[drp_addr] = drp_di;
        pend_do = 16'($urandom);
        if (wr_lat != 0) begin
          pend = 1'b1;
          pend_cnt = wr_lat;
        end
      end else begin
        pend_do = dev_mem[drp_addr];
        if (rd_lat != 0) begin
          pend = 1'b1;
          pend_cnt = rd_lat;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] ref_mem [256];
  logic [15:0] exp_q [$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // k / m: read / write ready latency after EN (0 = no ready ever).
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [15:0] mask,
                        input logic [15:0] data, input int k, input int m);
    bit          rd_phase, wr_phase, tmo;
    logic [15:0] old_w, merged, exp_data;
    int          exp_lat, exp_en, exp_we, t0, en0, we0, n;
    logic [15:0] got_data;

    // Reference model from request semantics.
    rd_phase = !we || (mask != 16'hFFFF);
    wr_phase = we && (mask != 16'h0000);
    old_w    = ref_mem[addr];
    merged   = (old_w & ~mask) | (data & mask);
    tmo      = rd_phase && (k == 0 || k > TMO);
    if (tmo) begin
      exp_lat  = 1 + TMO + 1;
      exp_en   = 1;
      exp_we   = 0;
      exp_data = 16'h0000;
    end else begin
      exp_lat  = (rd_phase ? 1 + k : 0) + (wr_phase ? 1 + m : 0) + 1;
      exp_en   = (rd_phase ? 1 : 0) + (wr_phase ? 1 : 0);
      exp_we   = wr_phase ? 1 : 0;
      exp_data = we ? merged : old_w;
      if (wr_phase) ref_mem[addr] = merged;
    end
    exp_q.push_back(exp_data);

    rd_lat = k;
    wr_lat = m;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_bound", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    en0 = en_cnt;
    we0 = we_cnt;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_mask  = mask;
    req_data  = data;
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 8'($urandom);
    // Cycle 1: first DRP enable, request side busy.
    check("c1_en", drp_en, 1);
    check("c1_we", drp_we, rd_phase ? 0 : 1);
    check("c1_addr", drp_addr, addr);
    check("c1_ready", req_ready, 0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      check("rsp_bound", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    got_data = rsp_data;
    check("rsp_lat", cyc - t0, exp_lat);
    check("rsp_data", got_data, exp_q.pop_front());
    check("rsp_tmo", rsp_timeout, tmo);
    check("en_count", en_cnt - en0, exp_en);
    check("we_count", we_cnt - we0, exp_we);
    if (wr_phase && !tmo) check("wr_di", last_di, merged);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_en"}, drp_en, 0);
    check({tag, "_we"}, drp_we, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_tmo"}, rsp_timeout, 0);
    check({tag, "_addr"}, drp_addr, 0);
    check({tag, "_di"}, drp_di, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          en0, rsp_seen;
    logic [15:0] msk;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 16'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[8'h04] = 16'h1234; ref_mem[8'h04] = 16'h1234;
    dev_mem[8'h08] = 16'hA5A5; ref_mem[8'h08] = 16'hA5A5;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    // Directed cases.
    do_req(1'b0, 8'h04, 16'h0000, 16'h0000, 3, 1);      // read, k=3
    do_req(1'b1, 8'h08, 16'h00F0, 16'h0030, 1, 1);      // RMW -> A535
    do_req(1'b1, 8'h10, 16'hFFFF, 16'hBEEF, 1, 2);      // full-mask write
    do_req(1'b1, 8'h11, 16'h0000, 16'h5555, 2, 1);      // empty mask: read only
    do_req(1'b0, 8'h20, 16'h0000, 16'h0000, 0, 1);      // read timeout
    do_req(1'b1, 8'h21, 16'h0F0F, 16'h1234, 0, 1);      // RMW aborted in read
    do_req(1'b0, 8'h22, 16'h0000, 16'h0000, TMO, 1);    // ready in last wait cycle
    do_req(1'b1, 8'h23, 16'hF00F, 16'hABCD, TMO, TMO);  // both phases at the limit

    // Reset during RD_WAIT: no response, no further enables.
    @(negedge clk);
    rd_lat = 3;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h04;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    en0 = en_cnt;
    rsp_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check("rst_no_rsp", rsp_seen, 0);
    check("rst_no_en", en_cnt - en0, 0);
    do_req(1'b0, 8'h04, 16'h0000, 16'h0000, 2, 1);

    // Stray ready pulses while idle.
    en0 = en_cnt;
    rsp_seen = 0;
    repeat (5) begin
      stray = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check("stray_no_rsp", rsp_seen, 0);
    check("stray_no_en", en_cnt - en0, 0);

    // Random back-to-back traffic.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       msk = 16'h0000;
        1:       msk = 16'hFFFF;
        default: msk = 16'($urandom);
      endcase
      do_req(1'($urandom), 8'($urandom_range(0, 15)), msk, 16'($urandom),
             $urandom_range(1, TMO), $urandom_range(1, TMO));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
